// File: rtl/temporal_encoder_4.sv
// Binary-to-race-logic encoder feeding the 4-input bitonic sorter.
// Each accepted window turns NUM_LINES binary values into active-low
// temporal lines. Line i falls val_i edges after the accept edge and stays
// low until the window closes. After that, every line is held at 1 for a
// short recovery gap before the next window can be accepted.
module temporal_encoder_4 #(
    parameter int NUM_LINES = 4,
    parameter int VAL_W     = 6,
    parameter int GAMMA_LEN = 48,
    parameter int REC_LEN   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_LINES*VAL_W-1:0] vals,
    output logic                       ready,
    output logic                       busy,
    output logic [0:NUM_LINES-1]       spikes,
    output logic                       gamma_done
);

    localparam int RC_W = $clog2(REC_LEN + 1);
    localparam logic [VAL_W-1:0] CNT_LAST = VAL_W'(GAMMA_LEN - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REC_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RECOVER
    } state_t;

    state_t                 state_reg, state_next;
    logic [VAL_W-1:0]       cnt_reg, cnt_next, cnt_inc;
    logic [RC_W-1:0]        rcnt_reg, rcnt_next;
    logic [VAL_W-1:0]       val_reg  [NUM_LINES];
    logic [VAL_W-1:0]       val_next [NUM_LINES];
    logic [VAL_W-1:0]       vals_in  [NUM_LINES];
    logic [0:NUM_LINES-1]   spikes_reg, spikes_next;
    logic [0:NUM_LINES-1]   accept_spk, run_spk;
    logic                   gamma_done_reg, gamma_done_next;

    // Count that the window reaches at the coming edge; it never wraps
    // because the window closes while cnt_reg equals GAMMA_LEN-1.
    assign cnt_inc = cnt_reg + 1'b1;

    // Per-line unpacking and comparators. A line is low once its value is
    // <= the current count, so it falls exactly at edge E(val) and, since
    // the count only increases, never rises again inside the window.
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            assign vals_in[gi]    = vals[gi*VAL_W +: VAL_W];
            assign accept_spk[gi] = (vals_in[gi] != '0);
            assign run_spk[gi]    = ~(val_reg[gi] <= cnt_inc);
        end
    endgenerate

    // Next-state and next-output decode for the IDLE/RUN/RECOVER sequence.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        rcnt_next       = rcnt_reg;
        spikes_next     = spikes_reg;
        gamma_done_next = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            val_next[i] = val_reg[i];
        end

        case (state_reg)
            S_IDLE: begin
                spikes_next = '1;
                if (start) begin
                    for (int i = 0; i < NUM_LINES; i++) begin
                        val_next[i] = vals_in[i];
                    end
                    cnt_next    = '0;
                    spikes_next = accept_spk;
                    state_next  = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next      = S_RECOVER;
                    rcnt_next       = '0;
                    spikes_next     = '1;
                    gamma_done_next = 1'b1;
                end else begin
                    cnt_next    = cnt_inc;
                    spikes_next = run_spk;
                end
            end
            S_RECOVER: begin
                spikes_next = '1;
                if (rcnt_reg == RC_LAST) begin
                    state_next = S_IDLE;
                    rcnt_next  = '0;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next  = S_IDLE;
                spikes_next = '1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any window immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            rcnt_reg       <= '0;
            spikes_reg     <= '1;
            gamma_done_reg <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                val_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            rcnt_reg       <= rcnt_next;
            spikes_reg     <= spikes_next;
            gamma_done_reg <= gamma_done_next;
            for (int i = 0; i < NUM_LINES; i++) begin
                val_reg[i] <= val_next[i];
            end
        end
    end

    assign ready      = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign spikes     = spikes_reg;
    assign gamma_done = gamma_done_reg;

endmodule

// File: tb/tb_temporal_encoder_4.sv
// Self-checking bench for temporal_encoder_4: table of windows with
// expected fall edges, scoreboard queue of per-cycle expected line states,
// plus hand-written reset, abort, busy-start and back-to-back sequences.
module tb_temporal_encoder_4;

    localparam int G  = 48;
    localparam int R  = 4;
    localparam logic [7:0] NV = 8'd255;   // "never falls"

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [23:0] vals = '0;
    logic        ready;
    logic        busy;
    logic [0:3]  spikes;
    logic        gamma_done;

    temporal_encoder_4 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vals       (vals),
        .ready      (ready),
        .busy       (busy),
        .spikes     (spikes),
        .gamma_done (gamma_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0][5:0] v;      // line i value in v[i]
        logic [3:0][7:0] fall;   // edge index where line i falls
    } vec_t;

    vec_t       tbl [8];
    logic [0:3] exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:3] model(input vec_t t, input int k);
        logic [0:3] e;
        for (int i = 0; i < 4; i++) e[i] = (k < int'(t.fall[i]));
        return e;
    endfunction

    // Accept one window from table entry idx and check every cycle up to
    // the return of ready. inject_k >= 0 pulses start with other vals then.
    task automatic run_window(input int idx, input bit hold, input int inject_k,
                              output int acc_cyc);
        chk("ready_before_accept", 32'(ready), 32'd1);
        vals  = tbl[idx].v;
        start = 1'b1;
        for (int k = 0; k < G; k++) exp_q.push_back(model(tbl[idx], k));
        tick();
        acc_cyc = cyc;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_after_accept", 32'(ready), 32'd0);
        if (!hold) start = 1'b0;
        for (int k = 0; k < G; k++) begin
            if (k == inject_k) begin
                vals  = ~tbl[idx].v;
                start = 1'b1;
            end
            if (k == inject_k + 1 && !hold) start = 1'b0;
            if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
            else chk("spikes_run", 32'(spikes), 32'(exp_q.pop_front()));
            chk("gamma_done_run", 32'(gamma_done), 32'd0);
            tick();
        end
        chk("gamma_done_pulse", 32'(gamma_done), 32'd1);
        chk("spikes_window_end", 32'(spikes), 32'hf);
        chk("busy_window_end", 32'(busy), 32'd1);
        for (int r = 1; r <= R; r++) begin
            tick();
            chk("gamma_done_recover", 32'(gamma_done), 32'd0);
            chk("spikes_recover", 32'(spikes), 32'hf);
            chk("ready_recover", 32'(ready), (r == R) ? 32'd1 : 32'd0);
        end
        $display("window %0d vals=%h accepted at cycle %0d", idx, tbl[idx].v, acc_cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, a2;

        tbl[0].v = {6'd39, 6'd0, 6'd7, 6'd5};   tbl[0].fall = {8'd39, 8'd0, 8'd7, 8'd5};
        tbl[1].v = {6'd1, 6'd1, 6'd63, 6'd48};  tbl[1].fall = {8'd1, 8'd1, NV, NV};
        tbl[2].v = {6'd10, 6'd30, 6'd45, 6'd2}; tbl[2].fall = {8'd10, 8'd30, 8'd45, 8'd2};
        tbl[3].v = {6'd20, 6'd20, 6'd20, 6'd20}; tbl[3].fall = {8'd20, 8'd20, 8'd20, 8'd20};
        tbl[4].v = {6'd47, 6'd3, 6'd0, 6'd12};  tbl[4].fall = {8'd47, 8'd3, 8'd0, 8'd12};
        tbl[5].v = {6'd6, 6'd0, 6'd25, 6'd33};  tbl[5].fall = {8'd6, 8'd0, 8'd25, 8'd33};
        tbl[6].v = {6'd47, 6'd48, 6'd1, 6'd0};  tbl[6].fall = {8'd47, NV, 8'd1, 8'd0};
        tbl[7].v = {6'd0, 6'd0, 6'd0, 6'd0};    tbl[7].fall = {8'd0, 8'd0, 8'd0, 8'd0};

        // Reset asserted mid-cycle takes effect immediately.
        #22 rst = 1'b1;
        #1;
        chk("reset_spikes", 32'(spikes), 32'hf);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_gamma_done", 32'(gamma_done), 32'd0);
        #10 rst = 1'b0;
        tick();

        // Basic, no-spike and busy-start windows.
        run_window(0, 1'b0, -1, a0);
        run_window(1, 1'b0, -1, a0);
        run_window(2, 1'b0, 20, a0);

        // Abort in the middle of RUN.
        vals  = tbl[3].v;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk("abort_busy_before", 32'(busy), 32'd1);
        chk("abort_spikes_before", 32'(spikes), 32'hf);
        #3 rst = 1'b1;
        #1;
        chk("abort_spikes", 32'(spikes), 32'hf);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_gamma_done", 32'(gamma_done), 32'd0);
        tick();
        tick();
        chk("abort_hold_gamma_done", 32'(gamma_done), 32'd0);
        chk("abort_hold_spikes", 32'(spikes), 32'hf);
        #2 rst = 1'b0;
        run_window(4, 1'b0, -1, a0);

        // Back-to-back with start held high.
        run_window(5, 1'b1, -1, a0);
        run_window(6, 1'b1, -1, a1);
        run_window(7, 1'b1, -1, a2);
        start = 1'b0;
        chk("b2b_period_1", 32'(a1 - a0), 32'(G + R + 1));
        chk("b2b_period_2", 32'(a2 - a1), 32'(G + R + 1));
        tick();
        chk("idle_after_b2b", 32'(ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
